bus_dispatch_seq: RTL and testbench
===================================

Name: bus_dispatch_seq

Overview:
- Upstream sequencer for the 1-to-16 bus demultiplexer in MOPS-Hub.
- Accepts one request at a time, each carrying a target bus ID and a 16-bit word, over a valid/ready handshake.
- Drives the demux select and data bus for a fixed hold window, then waits for that channel's acknowledge, with a timeout.
- Returns a one-cycle response carrying a status code, and parks the select on an out-of-range value when idle so that every demux output reads zero.

Parameters:
- N_BUS, 16, number of downstream channels; valid IDs are 0..N_BUS-1.
- DATA_W, 16, width of the data word.
- SEL_W, 5, width of the select and bus-ID fields.
- HOLD_CYC, 2, number of cycles that sel/data_out/drive_en are asserted per request (allowed range 1..15).
- TIMEOUT, 255, maximum WAIT_ACK cycles before timeout (allowed range 1..65535).
- IDLE_SEL, 31, select value driven when no channel is addressed; must be >= N_BUS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_bus_id  in  SEL_W  target channel.
- req_data  in  DATA_W  word to deliver.
- ack_vec  in  N_BUS  per-channel acknowledge, level-sensitive.
- sel  out  SEL_W  demux select.
- data_out  out  DATA_W  demux input bus.
- drive_en  out  1  high while the hold window is active.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  2  response status: 00 OK, 01 TIMEOUT, 10 BAD_ID, 11 reserved.
- rsp_bus_id  out  SEL_W  ID of the request being answered.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_count  out  8  saturating count of non-OK responses.

Behaviour:
- All outputs are registered. req_ready is the only exception: it is decoded directly from state (req_ready = state==IDLE).
- Reset values:
  - state=IDLE, sel=IDLE_SEL, data_out=0, drive_en=0.
  - rsp_valid=0, rsp_status=00, rsp_bus_id=0, busy=0, err_count=0.
  - req_ready=1 in the first cycle after rst deasserts.
- Reset asserted mid-operation aborts the request with no response.
- FSM states:
  - IDLE:
    - req_ready=1. The request is accepted on req_valid & req_ready, and req_bus_id/req_data are latched.
    - If ID < N_BUS: go to DRIVE.
    - Otherwise: go to RESP with BAD_ID. sel never leaves IDLE_SEL in this case.
  - DRIVE:
    - sel=ID, data_out=data, drive_en=1 for exactly HOLD_CYC cycles.
    - A hold counter counts 0..HOLD_CYC-1.
    - An ack_latch flag is set if ack_vec[ID] is high in any DRIVE cycle.
    - Exit: if ack_latch is set, or ack_vec[ID] is high in the last DRIVE cycle, go to RESP with OK; otherwise go to WAIT_ACK.
  - WAIT_ACK:
    - sel=IDLE_SEL, data_out=0, drive_en=0.
    - The timeout counter starts at 0 and increments each cycle.
    - If ack_vec[ID] is high, go to RESP with OK.
    - Otherwise, once the counter reaches TIMEOUT-1, go to RESP with TIMEOUT.
    - If the ack arrives in that same final cycle, ack wins (OK).
  - RESP:
    - rsp_valid=1 for exactly one cycle, with rsp_status and rsp_bus_id.
    - err_count increments if status != OK, saturating at 255.
    - Next state is IDLE.
- Latency, with the accept edge at cycle T:
  - drive_en is high during T+1..T+HOLD_CYC.
  - Fastest rsp_valid is at T+HOLD_CYC+1.
  - A timeout rsp_valid is at T+HOLD_CYC+TIMEOUT+1.
  - A BAD_ID rsp_valid is at T+1.
  - Back-to-back requests: the next accept is possible in the cycle after RESP (IDLE).
- ack_vec bits other than ID are ignored in every state, and ack_vec is ignored in IDLE and RESP.
- req_valid is ignored while req_ready=0. The requester must hold its request until it is accepted.
- The upper SEL_W-4 bits of req_bus_id take part in the range check; IDs 16..31 are BAD_ID.

Decomposition:
- Shared package mopshub_dispatch_pkg holds:
  - the state enum (IDLE, DRIVE, WAIT_ACK, RESP);
  - status constants ST_OK, ST_TIMEOUT, ST_BAD_ID;
  - the IDLE_SEL default.
- One sub-module, dispatch_timer: a loadable up-counter with clear and terminal-count flag, instantiated twice (hold counter and timeout counter).

Test Plan:
- Reset check: hold rst for 3 cycles, then release -> sel=31, data_out=0, req_ready=1, err_count=0.
- OK in WAIT_ACK: with HOLD_CYC=2, send ID=5, data=16'hA5A5, and raise ack_vec[5] on the second WAIT_ACK cycle -> expect:
  - drive_en high for 2 cycles, with sel=5 and data_out=A5A5 throughout;
  - rsp_valid one cycle later with status 00 and rsp_bus_id=5.
- Bad ID: send ID=20 -> sel stays 31, drive_en never rises, rsp_valid at T+1 with status 10, err_count=1.
- Timeout: set TIMEOUT=8, send ID=15, keep ack_vec=0 except ack_vec[14]=1 -> status 01 at T+11, err_count increments.
- Early ack and back-to-back: raise ack_vec[0] during the first DRIVE cycle for ID=0 -> status 00 at T+3; immediately issue ID=1, which is accepted the cycle after RESP.
- Mid-flight reset and saturation:
  - Assert rst during WAIT_ACK -> no rsp_valid, and outputs return to reset values the next cycle.
  - Issue 260 BAD_ID requests -> err_count holds at 255.

Source files
------------

// File: rtl/mopshub_dispatch_pkg.sv
// mopshub_dispatch_pkg: shared FSM states, status codes and idle select for the bus dispatcher
package mopshub_dispatch_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_ACK, RESP} state_t;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_ID = 2'b10;
  localparam int IDLE_SEL_DEF = 31;
endpackage

// File: rtl/dispatch_timer.sv
// dispatch_timer: loadable up-counter with clear and terminal-count flag
module dispatch_timer #(
  parameter int W = 8,
  parameter int TC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count + 1'b1;
  assign tc = count == W'(TC);
endmodule

// File: rtl/bus_dispatch_seq.sv
// bus_dispatch_seq: sequences one request at a time onto the 1-to-N bus demux with hold window and ack timeout
module bus_dispatch_seq
  import mopshub_dispatch_pkg::*;
#(
  parameter int N_BUS = 16,
  parameter int DATA_W = 16,
  parameter int SEL_W = 5,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT = 255,
  parameter int IDLE_SEL = IDLE_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_bus_id,
  input  logic [DATA_W-1:0] req_data,
  input  logic [N_BUS-1:0]  ack_vec,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] data_out,
  output logic              drive_en,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [SEL_W-1:0]  rsp_bus_id,
  output logic              busy,
  output logic [7:0]        err_count
);
  localparam int IW = $clog2(N_BUS);
  state_t state, state_n;
  logic [SEL_W-1:0] id, id_n, sel_n, rsp_id_n;
  logic [DATA_W-1:0] data, data_n, dout_n;
  logic [1:0] st_n, status_n;
  logic [7:0] err_n;
  logic ack_latch, latch_n, ack_now, hold_tc, to_tc;
  assign req_ready = state == IDLE;
  assign ack_now = ack_vec[id[IW-1:0]];
  dispatch_timer #(.W(4), .TC(HOLD_CYC - 1)) u_hold (
    .clk(clk), .rst(rst), .clr(state != DRIVE), .en(state == DRIVE),
    .load(1'b0), .load_val(4'd0), .tc(hold_tc)
  );
  dispatch_timer #(.W(16), .TC(TIMEOUT - 1)) u_timeout (
    .clk(clk), .rst(rst), .clr(state != WAIT_ACK), .en(state == WAIT_ACK),
    .load(1'b0), .load_val(16'd0), .tc(to_tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      id <= '0;
      data <= '0;
      ack_latch <= 1'b0;
      sel <= SEL_W'(IDLE_SEL);
      data_out <= '0;
      drive_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_status <= ST_OK;
      rsp_bus_id <= '0;
      busy <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      id <= id_n;
      data <= data_n;
      ack_latch <= latch_n;
      sel <= sel_n;
      data_out <= dout_n;
      drive_en <= state_n == DRIVE;
      rsp_valid <= state_n == RESP;
      rsp_status <= status_n;
      rsp_bus_id <= rsp_id_n;
      busy <= state_n != IDLE;
      err_count <= err_n;
    end
  always_comb begin
    state_n = state;
    st_n = ST_OK;
    case (state)
      IDLE: if (req_valid) begin
        state_n = req_bus_id < SEL_W'(N_BUS) ? DRIVE : RESP;
        st_n = ST_BAD_ID;
      end
      DRIVE: if (hold_tc) state_n = (ack_latch || ack_now) ? RESP : WAIT_ACK;
      WAIT_ACK: if (ack_now || to_tc) begin
        state_n = RESP;
        st_n = ack_now ? ST_OK : ST_TIMEOUT;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the upcoming state so they align with it
  always_comb begin
    id_n = req_ready ? req_bus_id : id;
    data_n = req_ready ? req_data : data;
    latch_n = state == DRIVE && (ack_latch || ack_now);
    sel_n = state_n == DRIVE ? id_n : SEL_W'(IDLE_SEL);
    dout_n = state_n == DRIVE ? data_n : '0;
    status_n = state_n == RESP ? st_n : rsp_status;
    rsp_id_n = state_n == RESP ? id_n : rsp_bus_id;
    err_n = (state_n == RESP && st_n != ST_OK && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end
endmodule

// File: tb/tb_bus_dispatch_seq.sv
// tb_bus_dispatch_seq: randomized scoreboard bench for bus_dispatch_seq against a timing-level reference model
module tb_bus_dispatch_seq;
  localparam int H = 2;
  localparam int TO = 8;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, drive_en, rsp_valid, busy;
  logic [4:0] req_bus_id = 0, sel, rsp_bus_id;
  logic [15:0] req_data = 0, ack_vec = 0, data_out;
  logic [1:0] rsp_status;
  logic [7:0] err_count;
  typedef struct {int cyc; logic [1:0] st; logic [4:0] id; logic [7:0] err;} rsp_t;
  rsp_t q[$];
  int cyc = 0, tests = 0, fails = 0;
  bit chk_on = 0;
  logic exp_drive = 0, exp_busy = 0, exp_ready = 1;
  logic [4:0] exp_sel = 31;
  logic [15:0] exp_data = 0;
  logic [7:0] err_model = 0, cur_err = 0;

  bus_dispatch_seq #(.HOLD_CYC(H), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_bus_id(req_bus_id), .req_data(req_data), .ack_vec(ack_vec),
    .sel(sel), .data_out(data_out), .drive_en(drive_en), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_bus_id(rsp_bus_id), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_drive = 0;
    exp_sel = 31;
    exp_data = 0;
    exp_busy = 0;
    exp_ready = 1;
  endtask

  // k: period offset of a one-cycle ack pulse on the target bit (0 or beyond window = none)
  task automatic do_req(input logic [4:0] id, input logic [15:0] d, input int k,
                        input bit noise, input logic [15:0] other, input int abort_o);
    int t, r;
    logic [1:0] st;
    bit vid;
    vid = id < 16;
    t = cyc;
    req_valid = 1;
    req_bus_id = id;
    req_data = d;
    ack_vec = noise ? 16'($urandom) : other;
    if (!vid) begin r = t + 1; st = 2'b10; end
    else if (k >= 1 && k <= H) begin r = t + H + 1; st = 2'b00; end
    else if (k > H && k <= H + TO) begin r = t + k + 1; st = 2'b00; end
    else begin r = t + H + TO + 1; st = 2'b01; end
    if (abort_o == 0) begin
      if (st != 2'b00 && err_model != 8'hFF) err_model = err_model + 8'd1;
      q.push_back('{r, st, id, err_model});
    end
    for (int o = 1; o <= r - t; o++) begin
      step();
      req_valid = 0;
      req_bus_id = 5'($urandom);
      req_data = 16'($urandom);
      ack_vec = noise ? 16'($urandom) : other;
      if (vid && o <= H + TO) ack_vec[id[3:0]] = (o == k);
      exp_drive = vid && o <= H;
      exp_sel = exp_drive ? id : 5'd31;
      exp_data = exp_drive ? d : 16'd0;
      exp_busy = 1;
      exp_ready = 0;
      if (o == abort_o) begin
        rst = 1;
        step();
        rst = 0;
        set_idle();
        err_model = 0;
        cur_err = 0;
        return;
      end
    end
    step();
    set_idle();
    ack_vec = 16'($urandom);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, exp_busy);
        chk("drive_en", drive_en, exp_drive);
        chk("sel", sel, exp_sel);
        chk("data_out", data_out, exp_data);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("rsp_missing", 0, 1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          chk("rsp_valid", rsp_valid, 1);
          chk("rsp_status", rsp_status, q[0].st);
          chk("rsp_bus_id", rsp_bus_id, q[0].id);
          cur_err = q[0].err;
          void'(q.pop_front());
        end else chk("rsp_idle", rsp_valid, 0);
        chk("err_count", err_count, cur_err);
      end
    end
  end

  initial begin
    repeat (3) step();
    rst = 0;
    chk_on = 1;
    step();
    do_req(5'd5, 16'hA5A5, H + 2, 0, 16'h0000, 0);
    do_req(5'd20, 16'h1234, 0, 0, 16'h0000, 0);
    do_req(5'd15, 16'h0F0F, 0, 0, 16'h4000, 0);
    do_req(5'd0, 16'h00FF, 1, 0, 16'h0000, 0);
    do_req(5'd1, 16'hBEEF, 2, 0, 16'h0000, 0);
    for (int i = 0; i < 300; i++)
      do_req($urandom_range(0, 3) == 0 ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15)),
             16'($urandom), $urandom_range(0, H + TO + 3), 1, 16'h0000, 0);
    do_req(5'd7, 16'h7777, 0, 1, 16'h0000, H + 2);
    step();
    for (int i = 0; i < 260; i++)
      do_req(5'($urandom_range(16, 31)), 16'($urandom), 0, 1, 16'h0000, 0);
    repeat (3) step();
    chk("err_saturated", err_count, 8'hFF);
    chk("rsp_pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
